// File: rtl/bcd_counter_bank_if.sv
// Handshake bundle between the trigger path and the BCD counter bank.
// The producer drives pulses and selects; the bank returns display and status.
interface bcd_counter_bank_if #(
  parameter int DIGITS = 6
);
  logic                  inc_pulse;
  logic [DIGITS-1:0]     digit_sel;
  logic                  ref_pulse;
  logic                  clear;
  logic [4*DIGITS-1:0]   display_bcd;
  logic                  busy;
  logic                  overflow;

  modport master (
    output inc_pulse,
    output digit_sel,
    output ref_pulse,
    output clear,
    input  display_bcd,
    input  busy,
    input  overflow
  );

  modport slave (
    input  inc_pulse,
    input  digit_sel,
    input  ref_pulse,
    input  clear,
    output display_bcd,
    output busy,
    output overflow
  );
endinterface

// File: rtl/bcd_counter_bank.sv
// Decimal counter bank with one-digit-per-clock ripple carry.
// Display only latches settled values, never a half-propagated carry.
module bcd_counter_bank #(
  parameter int DIGITS = 6
) (
  input  logic clk,
  input  logic reset,
  bcd_counter_bank_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int W  = 4 * DIGITS;

  typedef enum logic {
    IDLE,
    ADD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]      cnt;
  logic [W-1:0]      cnt_upd;
  logic [W-1:0]      disp;
  logic [DIGITS-1:0] mask;
  logic [IW-1:0]     idx;
  logic              carry;
  logic              ref_pending;
  logic              ovf;

  logic [3:0] cur;
  logic [3:0] new_dig;
  logic       mbit;
  logic       cout;
  logic       last;
  logic [4:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!bus.clear && bus.inc_pulse)
          state_nxt = ADD;
      end
      ADD: begin
        if (bus.clear || last)
          state_nxt = IDLE;
      end
    endcase
  end

  // One digit slice of the adder, selected by idx
  always_comb begin
    cur  = 4'd0;
    mbit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur  = cnt[4*i +: 4];
        mbit = mask[i];
      end
    end
    sum = {1'b0, cur} + {4'd0, mbit} + {4'd0, carry};
    if (sum >= 5'd10) begin
      new_dig = 4'(sum - 5'd10);
      cout    = 1'b1;
    end else begin
      new_dig = sum[3:0];
      cout    = 1'b0;
    end
    cnt_upd = cnt;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i))
        cnt_upd[4*i +: 4] = new_dig;
    end
    last = (idx == IW'(DIGITS - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      disp        <= '0;
      mask        <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      ref_pending <= 1'b0;
      ovf         <= 1'b0;
    end else if (bus.clear) begin
      cnt         <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      ref_pending <= 1'b0;
      ovf         <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.inc_pulse) begin
        mask        <= bus.digit_sel;
        idx         <= '0;
        carry       <= 1'b0;
        ref_pending <= bus.ref_pulse;
      end else if (bus.ref_pulse) begin
        disp <= cnt;
      end
    end else begin
      cnt   <= cnt_upd;
      carry <= cout;
      idx   <= idx + IW'(1);
      if (last) begin
        idx         <= '0;
        ref_pending <= 1'b0;
        if (cout)
          ovf <= 1'b1;
        // Deferred refresh picks up the completed sum
        if (ref_pending || bus.ref_pulse)
          disp <= cnt_upd;
      end else if (bus.ref_pulse) begin
        ref_pending <= 1'b1;
      end
    end
  end

  assign bus.display_bcd = disp;
  assign bus.busy        = (state == ADD);
  assign bus.overflow    = ovf;
endmodule

// File: doc/bcd_counter_bank.md
Name: bcd_counter_bank

Overview:
- Consumer side of the debounced trigger path. Receives the single-cycle increment pulse, the per-digit select vector and the single-cycle refresh pulse.
- Holds a DIGITS-wide decimal (BCD) counter. Adds the selected digit weights with a sequential ripple carry, one digit per clock.
- Latches the counter into a display register only on refresh, so the display never shows a half-propagated carry.

Parameters:
- DIGITS, 6, number of BCD digits; legal range 1..8. Digit 0 is least significant.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- inc_pulse  input  1  single-cycle increment request
- digit_sel  input  DIGITS  digit positions to increment by one; sampled on the inc_pulse cycle
- ref_pulse  input  1  single-cycle display refresh request
- clear  input  1  synchronous clear of counter digits and overflow
- display_bcd  output  4*DIGITS  latched counter value; digit i occupies bits [4i+3:4i]
- busy  output  1  high while carry propagation is in progress
- overflow  output  1  sticky; set on carry out of the top digit

Behaviour:
- Reset (asynchronous):
  - all counter digits = 0; display_bcd = 0; busy = 0; overflow = 0.
  - state = IDLE; ref_pending = 0; add mask = 0; idx = 0; carry = 0.
- State machine with two states, IDLE and ADD:
  - IDLE, inc_pulse=1: capture mask <= digit_sel, idx <= 0, carry <= 0, go to ADD.
  - IDLE, inc_pulse=1 with digit_sel = 0: still enters ADD. Value is unchanged; busy timing is identical.
  - ADD, each cycle: sum = digit[idx] + mask[idx] + carry, range 0..11.
    - sum >= 10: digit[idx] <= sum - 10, carry <= 1.
    - otherwise: digit[idx] <= sum, carry <= 0.
    - idx <= idx + 1.
  - ADD, when idx == DIGITS-1: after the update, return to IDLE. If the final carry is 1, set overflow <= 1. The counter wraps modulo 10^DIGITS.
- Timing:
  - busy = 1 exactly in ADD, i.e. DIGITS cycles, beginning the cycle after inc_pulse.
  - Result is complete DIGITS cycles after inc_pulse. This is within the upstream 9-cycle refresh gap for DIGITS <= 8.
- inc_pulse while busy: ignored. No queueing, no state change.
- ref_pulse handling:
  - In IDLE and not entering ADD on the same cycle: display_bcd <= counter on the next edge.
  - While busy, or coincident with an inc_pulse accepted from IDLE: set ref_pending. Display is latched on the cycle ADD exits to IDLE, so it includes the completed increment. ref_pending then clears.
  - Multiple ref_pulses while pending collapse into a single latch.
- clear:
  - Zeroes all digits and overflow, aborts any ADD, returns to IDLE, and clears ref_pending.
  - Has priority over inc_pulse in the same cycle.
  - display_bcd is unchanged until the next refresh.
- Digit values are always 0..9. No binary-to-BCD path exists.
- Reset mid-ADD: immediate return to reset values. No partial result is retained.

Test Plan:
- Single increment: reset, inc_pulse with digit_sel=6'b000001, ref_pulse 9 cycles later -> busy high 6 cycles, display_bcd = 24'h000001.
- Ripple carry: counter=099999, inc digit_sel=000001, ref -> display 24'h100000, overflow=0, busy exactly 6 cycles.
- Multi-digit select with carry: counter=000909, digit_sel=000101 -> 001010.
- Overflow wrap: counter=999999, digit_sel=000001 -> display 000000, overflow=1. A second increment keeps overflow=1. clear -> overflow=0.
- Refresh while busy, and inc while busy:
  - ref_pulse 2 cycles after inc_pulse on 000009 -> display stays old value until ADD exits, then shows 000010 on the exit cycle.
  - A second inc_pulse during busy -> ignored; final value 000010.
- Reset mid-ADD: assert reset at ADD cycle 3 -> digits, display_bcd, busy and overflow all 0 immediately. After release, inc 000001 plus ref -> 000001.
